mdu_multicycle: RTL

- Parametrised successor of the pipeline's E-stage multiply/divide unit.
- Holds HI/LO and runs mult/div and multiply-accumulate ops over configurable latencies.
- Exposes a start/busy handshake that the D-stage stall logic consumes.
- Operand width and per-class latency are generic; the cancel path is for P7 exception flushing.

---
 rtl/mdu_if.sv | 14 +
 rtl/mdu_multicycle.sv | 107 ++++++++++
 2 files changed

// File: rtl/mdu_if.sv
// mdu_if: start/busy handshake, operands and HI/LO view between the E-stage and the multiply/divide unit
interface mdu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic [WIDTH-1:0] rdata;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, a, b, cancel, input rdata, busy, hi, lo);
  modport slave (input start, op, a, b, cancel, output rdata, busy, hi, lo);
endinterface

// File: rtl/mdu_multicycle.sv
// mdu_multicycle: multi-cycle mult/div/madd/msub unit holding HI/LO with a start/busy handshake
// Define MDU_CANCEL_EN to let cancel abort an in-flight op or suppress a same-cycle start/mthi/mtlo.
module mdu_multicycle #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [WIDTH-1:0]   hi, lo, hi_n, lo_n;
  logic [WIDTH-1:0]   a_q, b_q, pre_hi, pre_lo;
  logic [3:0]         op_q;
  logic               accept, cancel_eff, long_op, start_div;
  logic               sgn, is_div, neg_a, neg_b;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc, mac_res, res;
  logic [WIDTH-1:0]   mag_a, mag_b, q_u, r_u, q, r;
`ifdef MDU_CANCEL_EN
  assign cancel_eff = bus.cancel;
`else
  logic unused_cancel;
  assign unused_cancel = bus.cancel;
  assign cancel_eff = 1'b0;
`endif
  assign long_op   = bus.op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd11, 4'd12};
  assign start_div = bus.op inside {4'd3, 4'd4};
  assign sgn       = op_q inside {4'd1, 4'd3, 4'd9, 4'd11};
  assign is_div    = op_q inside {4'd3, 4'd4};
  // Sign- or zero-extending to 2*WIDTH makes one multiplier serve both signednesses modulo 2^(2*WIDTH).
  assign ext_a   = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
  assign ext_b   = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
  assign prod    = ext_a * ext_b;
  assign acc     = {pre_hi, pre_lo};
  assign mac_res = op_q inside {4'd9, 4'd10} ? acc + prod :
                   op_q inside {4'd11, 4'd12} ? acc - prod : prod;
  // Signed divide via magnitudes; MIN/-1 wraps back to MIN with zero remainder.
  assign neg_a = sgn & a_q[WIDTH-1];
  assign neg_b = sgn & b_q[WIDTH-1];
  assign mag_a = neg_a ? -a_q : a_q;
  assign mag_b = neg_b ? -b_q : b_q;
  assign q_u   = mag_b == '0 ? '0 : mag_a / mag_b;
  assign r_u   = mag_b == '0 ? '0 : mag_a % mag_b;
  assign q     = neg_a ^ neg_b ? -q_u : q_u;
  assign r     = neg_a ? -r_u : r_u;
  assign res   = is_div ? (b_q == '0 ? {hi, lo} : {r, q}) : mac_res;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    accept  = 1'b0;
    if (state == IDLE) begin
      if (!cancel_eff && bus.start && long_op) begin
        accept  = 1'b1;
        cnt_n   = start_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        state_n = RUN;
      end else if (!cancel_eff) begin
        hi_n = bus.op == 4'd7 ? bus.a : hi;
        lo_n = bus.op == 4'd8 ? bus.a : lo;
      end
    end else if (cancel_eff) begin
      cnt_n   = '0;
      state_n = IDLE;
    end else begin
      cnt_n = cnt - 1'b1;
      if (cnt == CW'(1)) begin
        {hi_n, lo_n} = res;
        state_n      = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      pre_hi <= '0;
      pre_lo <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      if (accept) begin
        a_q    <= bus.a;
        b_q    <= bus.b;
        op_q   <= bus.op;
        pre_hi <= hi;
        pre_lo <= lo;
      end
    end
  end
  assign bus.busy  = state == RUN;
  assign bus.hi    = hi;
  assign bus.lo    = lo;
  assign bus.rdata = bus.op == 4'd5 ? hi : bus.op == 4'd6 ? lo : '0;
endmodule
